// File: rtl/fft_mem_pkg.sv
// Shared types and constants for the ping-pong FFT working memory.
// Holds the bank ownership states and the legal read-latency range.
package fft_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        WORK  = 2'd2
    } bank_state_t;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    function automatic bit read_latency_ok(input int lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/fft_pingpong_ram_if.sv
// Fill-side and work-side signal bundle of the ping-pong FFT working memory.
// The master modport is the loader/engine side, the slave modport is the memory.
interface fft_pingpong_ram_if #(
    parameter int DATA_WIDTH   = 48,
    parameter int BUFFER_DEPTH = 512
);
    localparam int AW = $clog2(BUFFER_DEPTH);

    logic [AW-1:0]         i_fill_addr;
    logic [DATA_WIDTH-1:0] i_fill_data;
    logic                  i_fill_wr;
    logic                  i_fill_last;
    logic                  o_fill_ready;
    logic [AW-1:0]         i_addr_a;
    logic [AW-1:0]         i_addr_b;
    logic [DATA_WIDTH-1:0] i_data_a;
    logic [DATA_WIDTH-1:0] i_data_b;
    logic                  i_wr_en_a;
    logic                  i_wr_en_b;
    logic [DATA_WIDTH-1:0] o_data_a;
    logic [DATA_WIDTH-1:0] o_data_b;
    logic                  o_work_valid;
    logic                  o_work_bank;
    logic                  i_work_done;
    logic                  o_collision;
    logic                  o_overrun;

    modport master (
        output i_fill_addr, i_fill_data, i_fill_wr, i_fill_last,
        output i_addr_a, i_addr_b, i_data_a, i_data_b, i_wr_en_a, i_wr_en_b, i_work_done,
        input  o_fill_ready, o_data_a, o_data_b, o_work_valid, o_work_bank, o_collision, o_overrun
    );

    modport slave (
        input  i_fill_addr, i_fill_data, i_fill_wr, i_fill_last,
        input  i_addr_a, i_addr_b, i_data_a, i_data_b, i_wr_en_a, i_wr_en_b, i_work_done,
        output o_fill_ready, o_data_a, o_data_b, o_work_valid, o_work_bank, o_collision, o_overrun
    );

endinterface

// File: rtl/fft_bank_ram.sv
// One true-dual-port memory bank with a registered (read-before-write) read.
// Callers guarantee the two ports never write the same address in one cycle.
module fft_bank_ram #(
    parameter int DATA_WIDTH = 48,
    parameter int DEPTH      = 512,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AW-1:0]         addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  we_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]         addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  we_b,
    output logic [DATA_WIDTH-1:0] rd_data_b
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_a_reg;
    logic [DATA_WIDTH-1:0] rd_b_reg;

    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= data_a;
        if (we_b) mem[addr_b] <= data_b;
    end

    // Read registers are cleared so the read pipeline starts from zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_reg <= '0;
            rd_b_reg <= '0;
        end else begin
            rd_a_reg <= mem[addr_a];
            rd_b_reg <= mem[addr_b];
        end
    end

    assign rd_data_a = rd_a_reg;
    assign rd_data_b = rd_b_reg;

endmodule

// File: rtl/fft_pingpong_ram.sv
// Two-bank ping-pong working memory: the loader fills one bank while the engine
// works in place on the other, with write-first forwarding and collision arbitration.
module fft_pingpong_ram
    import fft_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 48,
    parameter int BUFFER_DEPTH = 512,
    parameter int READ_LATENCY = 1
) (
    input logic               clk,
    input logic               rst_n,
    fft_pingpong_ram_if.slave bus
);
    localparam int AW       = $clog2(BUFFER_DEPTH);
    localparam bit LAT_OK   = read_latency_ok(READ_LATENCY);
    localparam bit OUT_REG  = LAT_OK && (READ_LATENCY == READ_LATENCY_MAX);

    bank_state_t state_reg  [2];
    bank_state_t state_next [2];
    logic fill_ptr_reg, fill_ptr_next;
    logic work_ptr_reg, work_ptr_next;
    logic overrun_reg, overrun_next;
    logic collision_reg, collision_next;

    logic fill_ready, work_valid, fill_we, we_a, we_b, same_addr;

    assign fill_ready = (state_reg[fill_ptr_reg] == EMPTY);
    assign work_valid = (state_reg[work_ptr_reg] == WORK);
    assign fill_we    = bus.i_fill_wr & fill_ready;
    assign same_addr  = (bus.i_addr_a == bus.i_addr_b);
    assign we_a       = bus.i_wr_en_a & work_valid;
    // Port A wins a same-address write; B's word is discarded.
    assign we_b           = bus.i_wr_en_b & work_valid & ~(we_a & same_addr);
    assign collision_next = we_a & bus.i_wr_en_b & same_addr;

    always_comb begin
        state_next    = state_reg;
        fill_ptr_next = fill_ptr_reg;
        work_ptr_next = work_ptr_reg;
        overrun_next  = overrun_reg;
        if (fill_we && bus.i_fill_last) begin
            state_next[fill_ptr_reg] = FULL;
            fill_ptr_next            = ~fill_ptr_reg;
        end
        if (bus.i_fill_wr && !fill_ready) overrun_next = 1'b1;
        if (state_reg[work_ptr_reg] == FULL) state_next[work_ptr_reg] = WORK;
        if (bus.i_work_done && work_valid) begin
            state_next[work_ptr_reg] = EMPTY;
            work_ptr_next            = ~work_ptr_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg[0]  <= EMPTY;
            state_reg[1]  <= EMPTY;
            fill_ptr_reg  <= 1'b0;
            work_ptr_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fill_ptr_reg  <= fill_ptr_next;
            work_ptr_reg  <= work_ptr_next;
            overrun_reg   <= overrun_next;
            collision_reg <= collision_next;
        end
    end

    logic [DATA_WIDTH-1:0] q_a [2];
    logic [DATA_WIDTH-1:0] q_b [2];

    // The fill side borrows port A of whichever bank the engine does not own.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        localparam logic BANK = 1'(gi);
        logic                  own_work;
        logic [AW-1:0]         addr_a;
        logic [DATA_WIDTH-1:0] data_a;
        logic                  wr_a;

        assign own_work = work_valid && (work_ptr_reg == BANK);

        always_comb begin
            if (own_work) begin
                addr_a = bus.i_addr_a;
                data_a = bus.i_data_a;
                wr_a   = we_a;
            end else begin
                addr_a = bus.i_fill_addr;
                data_a = bus.i_fill_data;
                wr_a   = fill_we && (fill_ptr_reg == BANK);
            end
        end

        fft_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BUFFER_DEPTH)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .addr_a    (addr_a),
            .data_a    (data_a),
            .we_a      (wr_a),
            .rd_data_a (q_a[gi]),
            .addr_b    (bus.i_addr_b),
            .data_b    (bus.i_data_b),
            .we_b      (we_b && own_work),
            .rd_data_b (q_b[gi])
        );
    end

    logic                  fwd_hit_a_next, fwd_hit_b_next;
    logic [DATA_WIDTH-1:0] fwd_data_a_next, fwd_data_b_next;
    logic                  fwd_hit_a_reg, fwd_hit_b_reg, rd_bank_reg;
    logic [DATA_WIDTH-1:0] fwd_data_a_reg, fwd_data_b_reg;
    logic [DATA_WIDTH-1:0] data_a_s1, data_b_s1;

    // Banks read old data; a same-cycle write to the read address overrides it.
    always_comb begin
        fwd_hit_a_next  = 1'b0;
        fwd_data_a_next = bus.i_data_a;
        fwd_hit_b_next  = 1'b0;
        fwd_data_b_next = bus.i_data_b;
        if (we_a) begin
            fwd_hit_a_next = 1'b1;
        end else if (we_b && same_addr) begin
            fwd_hit_a_next  = 1'b1;
            fwd_data_a_next = bus.i_data_b;
        end
        if (we_a && same_addr) begin
            fwd_hit_b_next  = 1'b1;
            fwd_data_b_next = bus.i_data_a;
        end else if (we_b) begin
            fwd_hit_b_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit_a_reg  <= 1'b0;
            fwd_hit_b_reg  <= 1'b0;
            fwd_data_a_reg <= '0;
            fwd_data_b_reg <= '0;
            rd_bank_reg    <= 1'b0;
        end else begin
            fwd_hit_a_reg  <= fwd_hit_a_next;
            fwd_hit_b_reg  <= fwd_hit_b_next;
            fwd_data_a_reg <= fwd_data_a_next;
            fwd_data_b_reg <= fwd_data_b_next;
            rd_bank_reg    <= work_ptr_reg;
        end
    end

    assign data_a_s1 = fwd_hit_a_reg ? fwd_data_a_reg : q_a[rd_bank_reg];
    assign data_b_s1 = fwd_hit_b_reg ? fwd_data_b_reg : q_b[rd_bank_reg];

    if (OUT_REG) begin : g_out_reg
        logic [DATA_WIDTH-1:0] data_a_reg, data_b_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_a_reg <= '0;
                data_b_reg <= '0;
            end else begin
                data_a_reg <= data_a_s1;
                data_b_reg <= data_b_s1;
            end
        end
        assign bus.o_data_a = data_a_reg;
        assign bus.o_data_b = data_b_reg;
    end else begin : g_out_direct
        assign bus.o_data_a = data_a_s1;
        assign bus.o_data_b = data_b_s1;
    end

    assign bus.o_fill_ready = fill_ready;
    assign bus.o_work_valid = work_valid;
    assign bus.o_work_bank  = work_ptr_reg;
    assign bus.o_collision  = collision_reg;
    assign bus.o_overrun    = overrun_reg;

endmodule

// File: tb/tb_fft_pingpong_ram.sv
// Scoreboard bench for fft_pingpong_ram: one instance at read latency 1 and one at 2,
// driven by identical stimulus; read checks are queued and retired by a monitor.
module tb_fft_pingpong_ram;
    localparam int DW    = 48;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fft_pingpong_ram_if #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) bus1 ();
    fft_pingpong_ram_if #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) bus2 ();

    assign bus2.i_fill_addr = bus1.i_fill_addr;
    assign bus2.i_fill_data = bus1.i_fill_data;
    assign bus2.i_fill_wr   = bus1.i_fill_wr;
    assign bus2.i_fill_last = bus1.i_fill_last;
    assign bus2.i_addr_a    = bus1.i_addr_a;
    assign bus2.i_addr_b    = bus1.i_addr_b;
    assign bus2.i_data_a    = bus1.i_data_a;
    assign bus2.i_data_b    = bus1.i_data_b;
    assign bus2.i_wr_en_a   = bus1.i_wr_en_a;
    assign bus2.i_wr_en_b   = bus1.i_wr_en_b;
    assign bus2.i_work_done = bus1.i_work_done;

    fft_pingpong_ram #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    fft_pingpong_ram #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        bit            pb;
        logic [DW-1:0] exp;
        string         name;
    } rd_entry_t;

    rd_entry_t q1[$];
    rd_entry_t q2[$];
    int errors = 0;
    int checks = 0;
    logic rd_chk = 1'b0;
    logic tag1   = 1'b0;
    logic tag2   = 1'b0;

    always @(posedge clk) begin
        tag1 <= rd_chk;
        tag2 <= tag1;
    end

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
        else $display("ok   %s: %h", name, act);
    endtask

    always @(negedge clk) begin : monitor
        rd_entry_t e;
        if (tag1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb1_underflow: got empty queue expected entry");
            end else begin
                e = q1.pop_front();
                cmp({e.name, "_L1"}, e.pb ? bus1.o_data_b : bus1.o_data_a, e.exp);
            end
        end
        if (tag2) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb2_underflow: got empty queue expected entry");
            end else begin
                e = q2.pop_front();
                cmp({e.name, "_L2"}, e.pb ? bus2.o_data_b : bus2.o_data_a, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus1.i_fill_addr = '0; bus1.i_fill_data = '0; bus1.i_fill_wr = 1'b0; bus1.i_fill_last = 1'b0;
        bus1.i_addr_a = '0; bus1.i_addr_b = '0; bus1.i_data_a = '0; bus1.i_data_b = '0;
        bus1.i_wr_en_a = 1'b0; bus1.i_wr_en_b = 1'b0; bus1.i_work_done = 1'b0;
        rd_chk = 1'b0;
    endtask

    // Expected flags are {fill_ready, work_valid, work_bank, overrun}.
    task automatic status(input string name, input logic [3:0] exp);
        cmp({name, "_st1"}, DW'({bus1.o_fill_ready, bus1.o_work_valid, bus1.o_work_bank, bus1.o_overrun}), DW'(exp));
        cmp({name, "_st2"}, DW'({bus2.o_fill_ready, bus2.o_work_valid, bus2.o_work_bank, bus2.o_overrun}), DW'(exp));
    endtask

    task automatic collision(input string name, input logic exp);
        cmp({name, "_col1"}, DW'(bus1.o_collision), DW'(exp));
        cmp({name, "_col2"}, DW'(bus2.o_collision), DW'(exp));
    endtask

    task automatic rd(input bit pb, input int addr, input longint exp, input string name);
        rd_entry_t e;
        if (pb) bus1.i_addr_b = AW'(addr);
        else    bus1.i_addr_a = AW'(addr);
        rd_chk = 1'b1;
        e.pb = pb; e.exp = DW'(exp); e.name = name;
        q1.push_back(e);
        q2.push_back(e);
    endtask

    task automatic fill_frame(input longint base, input bit done_at_last);
        for (int i = 0; i < DEPTH; i++) begin
            bus1.i_fill_wr   = 1'b1;
            bus1.i_fill_addr = AW'(i);
            bus1.i_fill_data = DW'(base + longint'(i));
            bus1.i_fill_last = (i == DEPTH - 1);
            bus1.i_work_done = done_at_last && (i == DEPTH - 1);
            tick();
        end
        idle();
    endtask

    task automatic reset_values(input string name);
        status(name, 4'b1000);
        collision(name, 1'b0);
        cmp({name, "_da1"}, bus1.o_data_a, '0);
        cmp({name, "_db1"}, bus1.o_data_b, '0);
        cmp({name, "_da2"}, bus2.o_data_a, '0);
        cmp({name, "_db2"}, bus2.o_data_b, '0);
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #1 reset_values("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Frame 0 into bank 0, hand-off to the engine one edge later
        fill_frame(48'h0, 1'b0);
        status("f0_last", 4'b1000);
        tick();
        status("f0_handoff", 4'b1100);
        rd(0, 5, 48'h5, "rdA5"); tick(); idle();
        rd(1, 511, 48'h1FF, "rdB511"); tick(); idle();

        // Same-address write from both ports
        bus1.i_wr_en_a = 1'b1; bus1.i_addr_a = 9'd7; bus1.i_data_a = 48'hAAA;
        bus1.i_wr_en_b = 1'b1; bus1.i_addr_b = 9'd7; bus1.i_data_b = 48'hBBB;
        tick(); idle();
        collision("col_pulse", 1'b1);
        tick();
        collision("col_clear", 1'b0);
        rd(0, 7, 48'hAAA, "rdA7"); tick(); idle();
        rd(1, 7, 48'hAAA, "rdB7"); tick(); idle();

        // Write-first forwarding across ports
        bus1.i_wr_en_b = 1'b1; bus1.i_addr_b = 9'd3; bus1.i_data_b = 48'h123;
        rd(0, 3, 48'h123, "fwdA3"); tick(); idle();
        collision("fwd_nocol", 1'b0);
        bus1.i_wr_en_a = 1'b1; bus1.i_addr_a = 9'd9; bus1.i_data_a = 48'h999;
        rd(1, 9, 48'h999, "fwdB9"); tick(); idle();
        rd(0, 3, 48'h123, "rdA3"); tick(); idle();

        // Frame 1 into bank 1 while the engine holds bank 0, then an overrun
        fill_frame(48'h1000, 1'b0);
        status("f1_last", 4'b0100);
        bus1.i_fill_wr = 1'b1; bus1.i_fill_addr = 9'd4; bus1.i_fill_data = 48'hDEAD;
        tick(); idle();
        status("overrun", 4'b0101);
        rd(0, 4, 48'h4, "rdA4_kept"); tick(); idle();

        bus1.i_work_done = 1'b1;
        tick(); idle();
        status("done0", 4'b1011);
        // Done and a work write while no bank is in WORK: both ignored
        bus1.i_work_done = 1'b1;
        bus1.i_wr_en_a = 1'b1; bus1.i_addr_a = 9'd5; bus1.i_data_a = 48'hBAD;
        tick(); idle();
        status("work1", 4'b1111);
        rd(0, 5, 48'h1005, "rdA5_b1"); tick(); idle();

        // Frame 2 last word coincides with release of bank 1
        fill_frame(48'h2000, 1'b1);
        status("simul", 4'b1001);
        tick();
        status("simul_wv", 4'b1101);
        rd(0, 5, 48'h2005, "rdA5_b0"); tick(); idle();
        rd(1, 511, 48'h21FF, "rdB511_b0"); tick(); idle();
        repeat (3) tick();
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d/%0d pending expected 0", q1.size(), q2.size());
        end

        // Reset in the middle of a frame, away from any clock edge
        for (int i = 0; i < 3; i++) begin
            bus1.i_fill_wr = 1'b1; bus1.i_fill_addr = AW'(i); bus1.i_fill_data = DW'(i);
            tick();
        end
        idle();
        #2 rst_n = 1'b0;
        #1 reset_values("midreset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
